// File: rtl/fsm_mon_pkg.sv
// Shared encodings and the reference transition table for the one-hot control FSM monitor.
package fsm_mon_pkg;

    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_A    = 4'b0010;
    localparam logic [3:0] ST_B    = 4'b0100;
    localparam logic [3:0] ST_C    = 4'b1000;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_ENC     = 2'b01,
        FC_TRANS   = 2'b10,
        FC_TIMEOUT = 2'b11
    } fault_code_t;

    typedef enum logic [1:0] {
        M_INIT    = 2'b00,
        M_RUN     = 2'b01,
        M_FAULT   = 2'b10,
        M_RECOVER = 2'b11
    } mon_state_t;

    function automatic logic is_legal(input logic [3:0] s);
        return (s == ST_IDLE) || (s == ST_A) || (s == ST_B) || (s == ST_C);
    endfunction

    function automatic logic [3:0] next_state_ref(input logic [3:0] prev,
                                                  input logic       a,
                                                  input logic       b);
        logic [3:0] nxt;
        case (prev)
            ST_IDLE: nxt = a ? ST_A : ST_IDLE;
            ST_A:    nxt = b ? ST_B : ST_IDLE;
            ST_B:    nxt = ST_C;
            default: nxt = ST_IDLE;  // ST_C, and any corrupt vector falls back to IDLE
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fsm_mon_predict.sv
// Combinational prediction of the next one-hot state with encoding and transition error flags.
module fsm_mon_predict
    import fsm_mon_pkg::*;
(
    input  logic [3:0] prev_state,
    input  logic       prev_a,
    input  logic       prev_b,
    input  logic [3:0] state,
    output logic       enc_err,
    output logic       trans_err
);

    logic [3:0] expected;

    assign expected  = next_state_ref(prev_state, prev_a, prev_b);
    assign enc_err   = !is_legal(state);
    // A corrupt previous sample gives no trustworthy prediction, so it cannot flag a transition.
    assign trans_err = is_legal(prev_state) && (state != expected);

endmodule

// File: rtl/fsm_state_monitor.sv
// Integrity checker for the one-hot control FSM: sticky fault, cause code, saturating event count.
// Defining FSM_MON_RECOVERY_EN adds a timed recover_req pulse after a fault seen in M_RUN.
module fsm_state_monitor
    import fsm_mon_pkg::*;
#(
    parameter int TIMEOUT     = 8,
`ifdef FSM_MON_RECOVERY_EN
    parameter int RECOVER_CYC = 4,
`endif
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [3:0]       state,
    input  logic             cond_a,
    input  logic             cond_b,
    input  logic             clr_fault,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             recover_req,
    output logic [1:0]       mon_state
);

    localparam int SW = $clog2(TIMEOUT + 1);

    mon_state_t       mstate, mstate_nxt;
    fault_code_t      code_q, code_nxt, cause;
    logic             fault_q, fault_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [3:0]       prev_state;
    logic             prev_a, prev_b;
    logic [SW-1:0]    stall_cnt;
    logic             stall_hit, check_en, event_hit;
    logic             enc_err, trans_err;

    fsm_mon_predict u_predict (
        .prev_state (prev_state),
        .prev_a     (prev_a),
        .prev_b     (prev_b),
        .state      (state),
        .enc_err    (enc_err),
        .trans_err  (trans_err)
    );

    assign stall_hit = (stall_cnt == SW'(TIMEOUT));
    // Events keep counting while a fault is held; only M_INIT and M_RECOVER are blind.
    assign check_en  = (mstate == M_RUN) || (mstate == M_FAULT);

    always_comb begin
        cause = FC_NONE;
        if (enc_err)        cause = FC_ENC;
        else if (trans_err) cause = FC_TRANS;
        else if (stall_hit) cause = FC_TIMEOUT;
    end

    assign event_hit = check_en && (cause != FC_NONE);

`ifdef FSM_MON_RECOVERY_EN
    localparam int RW = $clog2(RECOVER_CYC + 1);
    logic [RW-1:0] rec_cnt;
    logic          rec_done;

    assign rec_done = (rec_cnt == RW'(RECOVER_CYC - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                 rec_cnt <= '0;
        else if (mstate == M_RECOVER) rec_cnt <= rec_cnt + 1'b1;
        else                         rec_cnt <= '0;
    end

    assign recover_req = (mstate == M_RECOVER);
`else
    assign recover_req = 1'b0;
`endif

    always_comb begin
        mstate_nxt = mstate;
        fault_nxt  = fault_q;
        code_nxt   = code_q;
        cnt_nxt    = cnt_q;
        if (event_hit && (cnt_q != {CNT_W{1'b1}})) cnt_nxt = cnt_q + 1'b1;
        case (mstate)
            M_INIT:  mstate_nxt = fault_q ? M_FAULT : M_RUN;
            M_RUN: begin
                if (event_hit) begin
                    fault_nxt = 1'b1;
                    code_nxt  = cause;
`ifdef FSM_MON_RECOVERY_EN
                    mstate_nxt = M_RECOVER;
`else
                    mstate_nxt = M_FAULT;
`endif
                end
            end
            M_FAULT: begin
                // A fresh event beats a simultaneous clear and replaces the held cause.
                if (event_hit) begin
                    if (clr_fault) code_nxt = cause;
                end else if (clr_fault) begin
                    fault_nxt  = 1'b0;
                    code_nxt   = FC_NONE;
                    mstate_nxt = M_RUN;
                end
            end
`ifdef FSM_MON_RECOVERY_EN
            M_RECOVER: if (rec_done) mstate_nxt = M_INIT;
`endif
            default: mstate_nxt = M_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mstate     <= M_INIT;
            fault_q    <= 1'b0;
            code_q     <= FC_NONE;
            cnt_q      <= '0;
            prev_state <= ST_IDLE;
            prev_a     <= 1'b0;
            prev_b     <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            mstate     <= mstate_nxt;
            fault_q    <= fault_nxt;
            code_q     <= code_nxt;
            cnt_q      <= cnt_nxt;
            prev_state <= state;
            prev_a     <= cond_a;
            prev_b     <= cond_b;
            if (state == ST_IDLE)  stall_cnt <= '0;
            else if (!stall_hit)   stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign illegal_cnt = cnt_q;
    assign mon_state   = mstate;

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Self-checking bench for fsm_state_monitor: vector table, directed corner sequences, random traffic.
module tb_fsm_state_monitor;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef FSM_MON_RECOVERY_EN
    localparam int RECOVER_CYC = 4;
`endif

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic [3:0]       state = 4'b0001;
    logic             cond_a = 1'b0;
    logic             cond_b = 1'b0;
    logic             clr_fault = 1'b0;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] illegal_cnt;
    logic             recover_req;
    logic [1:0]       mon_state;

    fsm_state_monitor #(
        .TIMEOUT (TIMEOUT),
`ifdef FSM_MON_RECOVERY_EN
        .RECOVER_CYC (RECOVER_CYC),
`endif
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .state       (state),
        .cond_a      (cond_a),
        .cond_b      (cond_b),
        .clr_fault   (clr_fault),
        .fault       (fault),
        .fault_code  (fault_code),
        .illegal_cnt (illegal_cnt),
        .recover_req (recover_req),
        .mon_state   (mon_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 resync, 1 watching, 2 fault held, 3 recovery window.
    int         m_mode, m_code, m_cnt, m_rem, m_run_len;
    bit         m_fault, mask_t;
    logic [3:0] m_prev;
    logic       m_pa, m_pb;

    function automatic logic [3:0] ref_next(input logic [3:0] p, input logic a, input logic b);
        int pos;
        if ($countones(p) != 1) return 4'b0001;
        pos = 0;
        for (int i = 0; i < 4; i++) if (p[i]) pos = i;
        if ((pos == 0 && !a) || (pos == 1 && !b)) return 4'b0001;
        return 4'(1 << ((pos + 1) % 4));
    endfunction

    task automatic model_reset();
        m_mode = 0; m_fault = 0; m_code = 0; m_cnt = 0; m_rem = 0;
        m_run_len = 0; m_prev = 4'b0001; m_pa = 0; m_pb = 0;
    endtask

    task automatic model_edge(input logic [3:0] st, input logic a, input logic b, input logic clr);
        int ev;
        ev = 0;
        if (m_mode == 1 || m_mode == 2) begin
            if ($countones(st) != 1) ev = 1;
            else if (!mask_t && $countones(m_prev) == 1 && st != ref_next(m_prev, m_pa, m_pb)) ev = 2;
            else if (m_run_len >= TIMEOUT) ev = 3;
        end
        if (ev != 0 && m_cnt < CNT_MAX) m_cnt++;
        case (m_mode)
            0: m_mode = m_fault ? 2 : 1;
            1: if (ev != 0) begin
                m_fault = 1;
                m_code  = ev;
`ifdef FSM_MON_RECOVERY_EN
                m_mode = 3;
                m_rem  = RECOVER_CYC;
`else
                m_mode = 2;
`endif
            end
            2: if (ev != 0) begin
                if (clr) m_code = ev;
            end else if (clr) begin
                m_fault = 0; m_code = 0; m_mode = 1;
            end
            default: begin
                m_rem--;
                if (m_rem == 0) m_mode = 0;
            end
        endcase
        m_run_len = (st == 4'b0001) ? 0 : m_run_len + 1;
        m_prev = st; m_pa = a; m_pb = b;
    endtask

    task automatic step(input logic [3:0] st, input logic a, input logic b, input logic clr);
        state = st; cond_a = a; cond_b = b; clr_fault = clr;
        @(posedge clk);
        model_edge(st, a, b, clr);
        #1;
        check("fault", fault, m_fault);
        check("fault_code", fault_code, m_code);
        check("illegal_cnt", illegal_cnt, m_cnt);
        check("recover_req", recover_req, m_mode == 3);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        state = 4'b0001; cond_a = 0; cond_b = 0; clr_fault = 0;
        model_reset();
        #1;
        check("rst_fault", fault, 0);
        check("rst_code", fault_code, 0);
        check("rst_cnt", illegal_cnt, 0);
        check("rst_recover", recover_req, 0);
        check("rst_mon_state", mon_state, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    typedef struct {
        logic [3:0] st;
        logic       a, b, clr;
        logic       e_fault;
        logic [1:0] e_code;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int hi_cycles;
        logic [3:0] st;
        int r;

        tbl[0]  = '{4'b0001, 1, 0, 0, 0, 2'b00, 8'd0};  // resync cycle
        tbl[1]  = '{4'b0010, 0, 1, 0, 0, 2'b00, 8'd0};
        tbl[2]  = '{4'b0100, 0, 0, 0, 0, 2'b00, 8'd0};
        tbl[3]  = '{4'b1000, 0, 0, 0, 0, 2'b00, 8'd0};
        tbl[4]  = '{4'b0001, 0, 0, 0, 0, 2'b00, 8'd0};
        tbl[5]  = '{4'b0001, 0, 0, 0, 0, 2'b00, 8'd0};
        tbl[6]  = '{4'b0011, 0, 0, 0, 1, 2'b01, 8'd1};  // bad encoding
        tbl[7]  = '{4'b0001, 0, 0, 0, 1, 2'b01, 8'd1};
        tbl[8]  = '{4'b0001, 1, 0, 1, 0, 2'b00, 8'd1};  // clear
        tbl[9]  = '{4'b0010, 0, 0, 0, 0, 2'b00, 8'd1};
        tbl[10] = '{4'b0100, 0, 0, 0, 1, 2'b10, 8'd2};  // A with cond_b=0 must return to IDLE
        tbl[11] = '{4'b1000, 0, 0, 1, 0, 2'b00, 8'd2};
        tbl[12] = '{4'b0001, 0, 0, 0, 0, 2'b00, 8'd2};
        tbl[13] = '{4'b1000, 0, 0, 0, 1, 2'b10, 8'd3};
        tbl[14] = '{4'b0000, 0, 0, 1, 1, 2'b01, 8'd4};  // clear loses to event, code replaced
        tbl[15] = '{4'b0000, 0, 0, 0, 1, 2'b01, 8'd5};
        tbl[16] = '{4'b0001, 0, 0, 1, 0, 2'b00, 8'd5};

        mask_t = 0;
        #2;
        do_reset();

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].st, tbl[i].a, tbl[i].b, tbl[i].clr);
            check($sformatf("tbl%0d_fault", i), fault, tbl[i].e_fault);
            check($sformatf("tbl%0d_code", i), fault_code, tbl[i].e_code);
            check($sformatf("tbl%0d_cnt", i), illegal_cnt, tbl[i].e_cnt);
        end

        // Twenty legal laps leave everything quiet.
        for (int i = 0; i < 20; i++) begin
            step(4'b0001, 1, 0, 0);
            step(4'b0010, 0, 1, 0);
            step(4'b0100, 0, 0, 0);
            step(4'b1000, 0, 0, 0);
        end
        check("legal_laps_fault", fault, 0);
        check("legal_laps_cnt", illegal_cnt, 5);

        // Stall in B: the transition check trips before the timeout.
        step(4'b0001, 1, 0, 0);
        step(4'b0010, 0, 1, 0);
        repeat (10) step(4'b0100, 0, 0, 0);
        check("stall_code_trans", fault_code, 2'b10);
        step(4'b1000, 0, 0, 0);
        step(4'b0001, 0, 0, 0);
        step(4'b0001, 0, 0, 1);
        check("stall_cleared", fault, 0);

        // Same stall with the transition flag held low: timeout is the first cause.
        force dut.trans_err = 1'b0;
        mask_t = 1;
        step(4'b0001, 1, 0, 0);
        step(4'b0010, 0, 1, 0);
        repeat (7) step(4'b0100, 0, 0, 0);
        check("stall_not_yet", fault, 0);
        repeat (3) step(4'b0100, 0, 0, 0);
        check("stall_code_timeout", fault_code, 2'b11);
        release dut.trans_err;
        mask_t = 0;
        step(4'b1000, 0, 0, 0);
        step(4'b0001, 0, 0, 0);
        step(4'b0001, 0, 0, 1);
        check("timeout_cleared", fault, 0);

        // Held bad encoding counts every cycle and saturates.
        repeat (300) step(4'b0000, 0, 0, 0);
        check("sat_cnt", illegal_cnt, CNT_MAX);
        step(4'b0000, 0, 0, 1);
        check("sat_clr_event_fault", fault, 1);
        check("sat_cnt_held", illegal_cnt, CNT_MAX);

        // Reset while the fault is held clears outputs at once.
        do_reset();

`ifdef FSM_MON_RECOVERY_EN
        repeat (3) step(4'b0001, 0, 0, 0);
        step(4'b0110, 0, 0, 0);
        hi_cycles = 0;
        if (recover_req) hi_cycles++;
        for (int i = 0; i < 8; i++) begin
            step(4'b0000, 0, 0, 0);
            if (recover_req) hi_cycles++;
        end
        check("recover_width", hi_cycles, RECOVER_CYC);
        check("recover_fault_held", fault, 1);
        do_reset();
        repeat (2) step(4'b0001, 0, 0, 0);
        step(4'b0110, 0, 0, 0);
        step(4'b0001, 0, 0, 0);
        check("recover_mid_high", recover_req, 1);
        do_reset();
`endif

        // Random traffic, mostly legal with sporadic corruption and clears.
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      st = ref_next(m_prev, m_pa, m_pb);
            else if (r < 9) st = 4'(1 << $urandom_range(0, 3));
            else            st = 4'($urandom_range(0, 15));
            step(st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0);
            if (i == 1000) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
